// File: rtl/daisy_mbox_if.sv
// Host command, bus master and response signals of the daisy mailbox.
// master = host/bus-target side, slave = mailbox side.
interface daisy_mbox_if #(
  parameter int DEPTH = 4,
  parameter int AW = 16,
  parameter int DW = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          bus_req;
  logic          bus_we;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic          bus_ack;
  logic [DW-1:0] bus_rdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          busy;
  logic [CW-1:0] cmd_cnt;
  logic          err;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata,
    output bus_ack, bus_rdata, rsp_ready,
    input  cmd_ready, bus_req, bus_we, bus_addr,
    input  bus_wdata, rsp_valid, rsp_data,
    input  busy, cmd_cnt, err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata,
    input  bus_ack, bus_rdata, rsp_ready,
    output cmd_ready, bus_req, bus_we, bus_addr,
    output bus_wdata, rsp_valid, rsp_data,
    output busy, cmd_cnt, err
  );
endinterface

// File: rtl/daisy_mbox.sv
// Command FIFO feeding a single-outstanding bus master with read responses.
// Optional ack timeout: define DAISY_MBOX_TIMEOUT_EN.
module daisy_mbox #(
  parameter int DEPTH = 4,
  parameter int AW = 16,
  parameter int DW = 32,
  parameter int TMO = 255
) (
  input logic clk,
  input logic rest,
  daisy_mbox_if.slave mb
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = AW + DW + 1;
  localparam logic [31:0] DEAD = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  state_t state, state_nx;

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] cnt;
  logic          ready, push, pop, tmo, err_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q, rdata_q;

  assign ready = cnt < CW'(DEPTH);
  assign push  = mb.cmd_valid && ready;
  assign pop   = (state == IDLE) && (cnt != '0);

  always_ff @(posedge clk) begin
    if (push)
      mem[wptr] <= {mb.cmd_op, mb.cmd_addr, mb.cmd_wdata};
  end

  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (pop && !push) cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rest) begin
    if (rest) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (pop) state_nx = ISSUE;
      ISSUE: if (mb.bus_ack || tmo)
               state_nx = we_q ? IDLE : RESP;
      RESP:  if (mb.rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Entry stored as {op, addr, wdata}; op=1 is a read, so we = ~op.
  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (pop) begin
        we_q    <= ~mem[rptr][EW-1];
        addr_q  <= mem[rptr][EW-2:DW];
        wdata_q <= mem[rptr][DW-1:0];
      end
      if (state == ISSUE && !we_q) begin
        if (mb.bus_ack) rdata_q <= mb.bus_rdata;
        else if (tmo)   rdata_q <= DW'(DEAD);
      end
    end
  end

`ifdef DAISY_MBOX_TIMEOUT_EN
  localparam int TW = $clog2(TMO + 1);
  logic [TW-1:0] tcnt;

  assign tmo = (state == ISSUE) && !mb.bus_ack &&
               (tcnt == TW'(TMO - 1));

  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      tcnt  <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == ISSUE && !mb.bus_ack && !tmo)
        tcnt <= tcnt + 1'b1;
      else
        tcnt <= '0;
      if (tmo) err_q <= 1'b1;
    end
  end
`else
  assign tmo   = 1'b0;
  // Without the timeout, err is constant 0 (TMO is never negative).
  assign err_q = (TMO < 0);
`endif

  assign mb.cmd_ready = ready;
  assign mb.cmd_cnt   = cnt;
  assign mb.bus_req   = (state == ISSUE);
  assign mb.bus_we    = we_q;
  assign mb.bus_addr  = addr_q;
  assign mb.bus_wdata = wdata_q;
  assign mb.rsp_valid = (state == RESP);
  assign mb.rsp_data  = rdata_q;
  assign mb.busy      = (state != IDLE) || (cnt != '0);
  assign mb.err       = err_q;
endmodule

// File: tb/tb_daisy_mbox.sv
// Scoreboard bench for daisy_mbox: bus transactions and read
// responses are checked in order by independent monitors.
module tb_daisy_mbox;
  localparam int DEPTH = 4;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rest = 1'b1;
  always #5 clk = ~clk;

  daisy_mbox_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) mb();

  daisy_mbox #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .TMO(TMO)) dut (
    .clk  (clk),
    .rest (rest),
    .mb   (mb)
  );

  int total = 0;
  int bad = 0;

  logic [48:0] bus_q[$];
  logic [31:0] rsp_q[$];

  int ack_mode = 0;
  int ack_dly = 1;
  int acnt = 0;
  logic [31:0] rd_val = '0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Bus monitor: every acked transaction must match the next expected one.
  initial forever begin
    @(negedge clk);
    if (!rest && mb.bus_req && mb.bus_ack) begin
      if (bus_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL bus_unexpected: got %0h want none",
                 {mb.bus_we, mb.bus_addr, mb.bus_wdata});
      end else begin
        chk("bus_txn", {15'd0, mb.bus_we, mb.bus_addr, mb.bus_wdata},
            {15'd0, bus_q.pop_front()});
      end
    end
  end

  // Response monitor.
  initial forever begin
    @(negedge clk);
    if (!rest && mb.rsp_valid && mb.rsp_ready) begin
      if (rsp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp_unexpected: got %0h want none", mb.rsp_data);
      end else begin
        chk("rsp_data", {32'd0, mb.rsp_data}, {32'd0, rsp_q.pop_front()});
      end
    end
  end

  // Bus target: ack_mode 0 = ack after ack_dly cycles, 1 = never, 2 = manual.
  initial forever begin
    @(posedge clk);
    #1;
    if (ack_mode != 2) begin
      if (mb.bus_ack || !mb.bus_req || ack_mode == 1) begin
        mb.bus_ack = 1'b0;
        acnt = 0;
      end else begin
        acnt++;
        if (acnt >= ack_dly) begin
          mb.bus_ack = 1'b1;
          mb.bus_rdata = rd_val;
          acnt = 0;
        end
      end
    end
  end

  task automatic send(input logic op, input logic [15:0] a,
                      input logic [31:0] d);
    bit ok = 0;
    mb.cmd_valid = 1'b1;
    mb.cmd_op = op;
    mb.cmd_addr = a;
    mb.cmd_wdata = d;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (mb.cmd_ready) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    mb.cmd_valid = 1'b0;
    chk("send_accept", 64'(ok), 64'd1);
  endtask

  task automatic wait_idle(input string nm);
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!mb.busy) begin
        ok = 1;
        break;
      end
    end
    chk(nm, 64'(ok), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    int rv;
    bit ok;
    mb.cmd_valid = 1'b0;
    mb.cmd_op = 1'b0;
    mb.cmd_addr = '0;
    mb.cmd_wdata = '0;
    mb.bus_ack = 1'b0;
    mb.bus_rdata = '0;
    mb.rsp_ready = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_cnt", 64'(mb.cmd_cnt), 64'd0);
    chk("rst_ready", 64'(mb.cmd_ready), 64'd1);
    chk("rst_busy", 64'(mb.busy), 64'd0);
    chk("rst_req", 64'(mb.bus_req), 64'd0);
    chk("rst_rsp", 64'(mb.rsp_valid), 64'd0);
    chk("rst_err", 64'(mb.err), 64'd0);
    chk("rst_addr", 64'(mb.bus_addr), 64'd0);
    chk("rst_rdata", 64'(mb.rsp_data), 64'd0);
    rest = 1'b0;
    @(posedge clk);
    #1;

    // Write with ack one cycle after request
    ack_dly = 1;
    bus_q.push_back({1'b1, 16'h0010, 32'hA5A5_A5A5});
    send(1'b0, 16'h0010, 32'hA5A5_A5A5);
    @(negedge clk);
    chk("lat_cnt", 64'(mb.cmd_cnt), 64'd1);
    chk("lat_req0", 64'(mb.bus_req), 64'd0);
    @(negedge clk);
    chk("lat_req1", 64'(mb.bus_req), 64'd1);
    chk("wr_we", 64'(mb.bus_we), 64'd1);
    len = 1;
    rv = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mb.bus_req) len++;
      if (mb.rsp_valid) rv++;
    end
    chk("wr_req_len", 64'(len), 64'd1);
    chk("wr_no_rsp", 64'(rv), 64'd0);
    chk("wr_busy", 64'(mb.busy), 64'd0);
    chk("wr_addr_hold", 64'(mb.bus_addr), 64'h10);

    // Read, ack after 3 cycles, response stalled 2 cycles
    @(posedge clk);
    #1;
    ack_dly = 3;
    rd_val = 32'h1234_5678;
    bus_q.push_back({1'b0, 16'h0020, 32'h0});
    rsp_q.push_back(32'h1234_5678);
    send(1'b1, 16'h0020, 32'h0);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (mb.rsp_valid) begin
        ok = 1;
        break;
      end
    end
    chk("rd_valid_seen", 64'(ok), 64'd1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rd_hold_v", 64'(mb.rsp_valid), 64'd1);
      chk("rd_hold_d", 64'(mb.rsp_data), 64'h1234_5678);
    end
    @(posedge clk);
    #1;
    mb.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    mb.rsp_ready = 1'b0;
    @(negedge clk);
    chk("rd_done_v", 64'(mb.rsp_valid), 64'd0);
    chk("rd_done_busy", 64'(mb.busy), 64'd0);
    ack_dly = 1;

    // Fill with acks held off: one in ISSUE, four in the FIFO
    ack_mode = 1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      bus_q.push_back({1'b1, 16'(16'h0100 + i), 32'(32'hC0DE_0000 + i)});
      send(1'b0, 16'(16'h0100 + i), 32'(32'hC0DE_0000 + i));
    end
    @(negedge clk);
    chk("fill_cnt3", 64'(mb.cmd_cnt), 64'd3);
    chk("fill_ready3", 64'(mb.cmd_ready), 64'd1);
    chk("fill_req", 64'(mb.bus_req), 64'd1);
    @(posedge clk);
    #1;
    bus_q.push_back({1'b1, 16'h0104, 32'hC0DE_0004});
    send(1'b0, 16'h0104, 32'hC0DE_0004);
    @(negedge clk);
    chk("full_cnt", 64'(mb.cmd_cnt), 64'd4);
    chk("full_ready", 64'(mb.cmd_ready), 64'd0);
    bus_q.push_back({1'b1, 16'h0105, 32'hC0DE_0005});
    fork
      send(1'b0, 16'h0105, 32'hC0DE_0005);
    join_none
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("full_stall_cnt", 64'(mb.cmd_cnt), 64'd4);
    end
    ack_mode = 0;
    for (int i = 0; i < 3; i++) @(negedge clk);
    wait_idle("fill_drain");

    // Reset during ISSUE with two queued
    ack_mode = 1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++)
      send(1'b1, 16'(16'h0200 + i), 32'h0);
    @(negedge clk);
    chk("pre_rst_cnt", 64'(mb.cmd_cnt), 64'd2);
    chk("pre_rst_req", 64'(mb.bus_req), 64'd1);
    #2;
    rest = 1'b1;
    #1;
    chk("mid_rst_req", 64'(mb.bus_req), 64'd0);
    chk("mid_rst_cnt", 64'(mb.cmd_cnt), 64'd0);
    chk("mid_rst_ready", 64'(mb.cmd_ready), 64'd1);
    chk("mid_rst_busy", 64'(mb.busy), 64'd0);
    chk("mid_rst_addr", 64'(mb.bus_addr), 64'd0);
    @(negedge clk);
    rest = 1'b0;
    ack_mode = 2;
    mb.bus_rdata = 32'hBAD0_BAD0;
    mb.bus_ack = 1'b1;
    rv = 0;
    len = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (mb.rsp_valid) rv++;
      if (mb.bus_req) len++;
    end
    mb.bus_ack = 1'b0;
    chk("stray_rsp", 64'(rv), 64'd0);
    chk("stray_req", 64'(len), 64'd0);
    chk("stray_busy", 64'(mb.busy), 64'd0);
    ack_mode = 0;

    // Push and pop on the same edge at cmd_cnt=2, across pointer wrap
    ack_mode = 1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++)
      bus_q.push_back({1'b1, 16'(16'h0300 + i), 32'(32'h5A00_0000 + i)});
    for (int i = 0; i < 3; i++)
      send(1'b0, 16'(16'h0300 + i), 32'(32'h5A00_0000 + i));
    @(negedge clk);
    chk("ovl_pre_cnt", 64'(mb.cmd_cnt), 64'd2);
    ack_mode = 0;
    for (int k = 3; k < 5; k++) begin
      ok = 0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (!mb.bus_req && !mb.rsp_valid && mb.cmd_cnt == 2) begin
          ok = 1;
          break;
        end
      end
      chk("ovl_found", 64'(ok), 64'd1);
      mb.cmd_valid = 1'b1;
      mb.cmd_op = 1'b0;
      mb.cmd_addr = 16'(16'h0300 + k);
      mb.cmd_wdata = 32'(32'h5A00_0000 + k);
      @(posedge clk);
      #1;
      mb.cmd_valid = 1'b0;
      @(negedge clk);
      chk("ovl_cnt", 64'(mb.cmd_cnt), 64'd2);
    end
    wait_idle("ovl_drain");

`ifdef DAISY_MBOX_TIMEOUT_EN
    // Read that is never acked times out
    ack_mode = 1;
    rsp_q.push_back(32'hDEAD_BEEF);
    @(posedge clk);
    #1;
    send(1'b1, 16'h0040, 32'h0);
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mb.bus_req) begin
        ok = 1;
        break;
      end
    end
    chk("tmo_req_seen", 64'(ok), 64'd1);
    len = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!mb.bus_req) break;
      len++;
    end
    chk("tmo_req_len", 64'(len), 64'd8);
    chk("tmo_rsp_v", 64'(mb.rsp_valid), 64'd1);
    chk("tmo_rsp_d", 64'(mb.rsp_data), 64'hDEAD_BEEF);
    chk("tmo_err", 64'(mb.err), 64'd1);
    @(posedge clk);
    #1;
    mb.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    mb.rsp_ready = 1'b0;
    @(negedge clk);
    chk("tmo_err_sticky", 64'(mb.err), 64'd1);
    chk("tmo_busy", 64'(mb.busy), 64'd0);
    rest = 1'b1;
    #1;
    chk("tmo_err_clr", 64'(mb.err), 64'd0);
    @(negedge clk);
    rest = 1'b0;
    ack_mode = 0;
`else
    chk("err_tied", 64'(mb.err), 64'd0);
`endif

    for (int i = 0; i < 3; i++) @(negedge clk);
    chk("bus_q_empty", 64'(bus_q.size()), 64'd0);
    chk("rsp_q_empty", 64'(rsp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
